// File: rtl/serial_ripple_sub.sv
// Bit-serial ripple subtractor: {bout,diff} = a - b - bin.
// A single full-subtractor cell is reused once per cycle, LSB first, with the
// ripple borrow carried between cycles in a flop. Operands arrive on a
// valid/ready request port and the result leaves on a valid/ready response
// port, WIDTH cycles after the request is accepted.
module serial_ripple_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d;
  logic             borrow_next;

  // Full-subtractor cell on the current LSBs; the new difference bit enters
  // the result register at the MSB so it is in place after WIDTH shifts.
  always_comb begin
    d           = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    r_next      = r_sh >> 1;
    r_next[WIDTH-1] = d;
  end

  // Handshake flags are pure decodes of the state register.
  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);

  // Control FSM and datapath registers; the final RUN edge also loads the
  // output registers so diff/bout only ever change on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            r_sh   <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          borrow <= borrow_next;
          r_sh   <= r_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= r_next;
            bout  <= borrow_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_sub.sv
// Self-checking bench for serial_ripple_sub at WIDTH = 4, 1 and 8.
// Expected results come from an arithmetic a - b - bin model and travel
// through a scoreboard queue from the request side to the response side.
module tb_serial_ripple_sub;

  typedef struct {
    logic [8:0] exp;
    int         cyc;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_s [3];
  logic [7:0] b_s [3];
  logic [2:0] bin_s;
  logic [2:0] sv;
  logic [2:0] rr;
  logic [2:0] sr;
  logic [2:0] rv;
  logic [2:0] bo;
  logic [3:0] d4;
  logic [0:0] d1;
  logic [7:0] d8;

  ent_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_ripple_sub #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
    .a(a_s[0][3:0]), .b(b_s[0][3:0]), .bin(bin_s[0]), .res_valid(rv[0]),
    .res_ready(rr[0]), .diff(d4), .bout(bo[0])
  );

  serial_ripple_sub #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
    .a(a_s[1][0:0]), .b(b_s[1][0:0]), .bin(bin_s[1]), .res_valid(rv[1]),
    .res_ready(rr[1]), .diff(d1), .bout(bo[1])
  );

  serial_ripple_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr[2]),
    .a(a_s[2]), .b(b_s[2]), .bin(bin_s[2]), .res_valid(rv[2]),
    .res_ready(rr[2]), .diff(d8), .bout(bo[2])
  );

  function automatic int wdt(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] wmask(input int k);
    case (k)
      0:       return 8'h0f;
      1:       return 8'h01;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic [7:0] getdf(input int k);
    case (k)
      0:       return {4'd0, d4};
      1:       return {7'd0, d1};
      default: return d8;
    endcase
  endfunction

  // 9-bit two's complement of a - b - bin: low bits are diff, bit 8 is the
  // sign, which is set exactly when a < b + bin.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic bi);
    return {1'b0, a} - {1'b0, b} - {8'd0, bi};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take(input int k, input int now, input bit chklat, input string tag);
    ent_t e;
    chk({tag, "/sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "/diff"}, 32'(getdf(k)), 32'(e.exp[7:0] & wmask(k)));
    chk({tag, "/bout"}, 32'(bo[k]), 32'(e.exp[8]));
    if (chklat) chk({tag, "/latency"}, 32'(now - e.cyc), 32'(wdt(k)));
  endtask

  // One directed WIDTH=4 operation; hold > 0 stalls the consumer that many
  // cycles while poking start_valid to show DONE ignores new requests.
  task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input int hold, input string tag);
    int lat;
    rr[0] = (hold == 0);
    lat = 0;
    while (!sr[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/idle_ready"}, 32'(sr[0]), 32'd1);
    a_s[0] = a; b_s[0] = b; bin_s[0] = bi; sv[0] = 1'b1;
    sb.push_back('{model(a, b, bi), 0});
    @(negedge clk);
    sv[0] = 1'b0; a_s[0] = ~a; b_s[0] = ~b; bin_s[0] = ~bi;
    chk({tag, "/busy_not_ready"}, 32'(sr[0]), 32'd0);
    lat = 0;
    while (!rv[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'd4);
    for (int h = 0; h < hold; h++) begin
      chk({tag, "/hold_valid"}, 32'(rv[0]), 32'd1);
      chk({tag, "/hold_diff"}, 32'(getdf(0)), 32'(sb[0].exp[3:0]));
      chk({tag, "/hold_bout"}, 32'(bo[0]), 32'(sb[0].exp[8]));
      chk({tag, "/hold_start_ready"}, 32'(sr[0]), 32'd0);
      sv[0] = 1'b1; a_s[0] = 8'd7;
      @(negedge clk);
    end
    sv[0] = 1'b0; rr[0] = 1'b1;
    take(0, 0, 1'b0, tag);
    @(negedge clk);
    chk({tag, "/valid_drop"}, 32'(rv[0]), 32'd0);
    chk({tag, "/back_idle"}, 32'(sr[0]), 32'd1);
  endtask

  // Back-to-back stream with start_valid and res_ready held high.
  task automatic stream(input int k, input int n, input bit exh, input bit spacing,
                        input string tag);
    int         t, issued, done, last;
    logic [7:0] ra, rb;
    logic       rbi;
    t = 0; issued = 0; done = 0; last = -1;
    rr[k] = 1'b1; sv[k] = 1'b1;
    while (done < n && t < n * (wdt(k) + 3) + 50) begin
      if (rv[k]) begin
        take(k, t, 1'b1, tag);
        done++;
      end
      if (sr[k]) begin
        if (issued < n) begin
          if (exh) begin
            ra  = 8'((issued >> 2) & 1);
            rb  = 8'((issued >> 1) & 1);
            rbi = 1'(issued & 1);
          end else begin
            ra  = 8'($urandom) & wmask(k);
            rb  = 8'($urandom) & wmask(k);
            rbi = 1'($urandom);
          end
          a_s[k] = ra; b_s[k] = rb; bin_s[k] = rbi; sv[k] = 1'b1;
          sb.push_back('{model(ra, rb, rbi), t + 1});
          if (spacing && last >= 0)
            chk({tag, "/spacing"}, 32'(t - last), 32'(wdt(k) + 2));
          last = t;
          issued++;
        end else begin
          sv[k] = 1'b0;
        end
      end
      @(negedge clk);
      t++;
    end
    chk({tag, "/completed"}, 32'(done), 32'(n));
    sv[k] = 1'b0; rr[k] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; sv = '0; rr = '0; bin_s = '0;
    for (int k = 0; k < 3; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end
    #2 rst_n = 1'b0;
    #2;
    chk("reset/start_ready", 32'(sr[0]), 32'd1);
    chk("reset/res_valid", 32'(rv[0]), 32'd0);
    chk("reset/diff", 32'(getdf(0)), 32'd0);
    chk("reset/bout", 32'(bo[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op4(8'd9, 8'd3, 1'b0, 0, "t1");
    op4(8'd3, 8'd9, 1'b0, 0, "t2a");
    op4(8'd0, 8'd0, 1'b1, 0, "t2b");
    op4(8'd5, 8'd5, 1'b0, 3, "t3");
    op4(8'd15, 8'd15, 1'b1, 0, "max_bin");
    op4(8'd0, 8'd15, 1'b0, 0, "zero_minus_max");

    // Reset two cycles into RUN: the partial result must never appear.
    while (!sr[0]) @(negedge clk);
    a_s[0] = 8'd12; b_s[0] = 8'd4; bin_s[0] = 1'b0; sv[0] = 1'b1; rr[0] = 1'b1;
    @(negedge clk);
    sv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4/rst_res_valid", 32'(rv[0]), 32'd0);
    chk("t4/rst_diff", 32'(getdf(0)), 32'd0);
    chk("t4/rst_bout", 32'(bo[0]), 32'd0);
    chk("t4/rst_start_ready", 32'(sr[0]), 32'd1);
    @(negedge clk);
    chk("t4/rst_hold_valid", 32'(rv[0]), 32'd0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t4/no_stale_result", 32'(rv[0]), 32'd0);
    end
    op4(8'd15, 8'd1, 1'b1, 0, "t4b");

    stream(0, 6, 1'b0, 1'b1, "t5");
    stream(1, 8, 1'b1, 1'b0, "w1");
    stream(2, 300, 1'b0, 1'b0, "w8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
